instr_mem_responder: RTL and testbench

- Memory-side responder for the core's instruction fetch interface (req/gnt/addr/rvalid/rdata).
- Holds a word-addressed instruction array, preloaded through a simple write port (boot loader / testbench).
- Accepts fetch requests and returns read data in order after a fixed, parameterised latency.
- Sits opposite the fetch stage in simulation and FPGA builds.

---
 rtl/instr_mem_responder.sv | 126 ++++++++++++
 tb/tb_instr_mem_responder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_responder.sv
// instr_mem_responder: memory-side responder for the core instruction fetch port.
// Latency: read data returns LATENCY cycles after the accept cycle, strictly in order.
// Backpressure: grant is withheld when MAX_OUTSTANDING responses are pending (a response
// retiring this cycle frees its slot immediately). Responses cannot be stalled.
// Optional build macro INSTR_MEM_GNT_STALL_EN adds LFSR-driven pseudo-random grant stalls.
module instr_mem_responder #(
  parameter int WORD_WIDTH      = 32,
  parameter int DEPTH_LOG2      = 10,
  parameter int LATENCY         = 1,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_req_i,
  input  logic [WORD_WIDTH-1:0] instr_addr_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  output logic [WORD_WIDTH-1:0] instr_rdata_o,
  input  logic                  load_we_i,
  input  logic [DEPTH_LOG2-1:0] load_addr_i,
  input  logic [WORD_WIDTH-1:0] load_wdata_i,
  output logic [2:0]            outstanding_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [2:0] MAX_W = 3'(MAX_OUTSTANDING);
  localparam logic [WORD_WIDTH-1:0] NOP_WORD = WORD_WIDTH'(32'h0000_0013);

  // Instruction array; not reset so a preload survives reset.
  logic [WORD_WIDTH-1:0] r_mem [DEPTH];

  // Response pipeline: stage 0 captures the read at accept, last stage drives the outputs.
  logic [LATENCY-1:0]    r_vld;
  logic [WORD_WIDTH-1:0] r_dat [LATENCY];

  logic [2:0]            r_cnt;

  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_oob;
  logic [WORD_WIDTH-1:0] w_rd;
  logic                  w_rvalid;
  logic [2:0]            w_eff_cnt;
  logic                  w_stall;
  logic                  w_accept;
  logic                  w_unused_addr_lsb;

  // Byte address to word index; the two low bits select a byte within the word and are dropped.
  assign w_idx             = instr_addr_i[DEPTH_LOG2+1:2];
  assign w_oob             = (instr_addr_i >> (DEPTH_LOG2 + 2)) != '0;
  assign w_unused_addr_lsb = ^instr_addr_i[1:0];

  // Asynchronous read so the word seen is the one present before this cycle's preload write.
  assign w_rd = w_oob ? NOP_WORD : r_mem[w_idx];

  assign w_rvalid = r_vld[LATENCY-1];

  // A slot retiring this cycle is already free, which gives full throughput at LATENCY=1.
  assign w_eff_cnt = r_cnt - {2'b00, w_rvalid};

`ifdef INSTR_MEM_GNT_STALL_EN
  logic [15:0] r_lfsr;

  // Fibonacci LFSR, taps 16,14,13,11, free-running; bit 0 withholds grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
    end
  end

  assign w_stall = r_lfsr[0];
`else
  assign w_stall = 1'b0;
`endif

  assign instr_gnt_o = instr_req_i && rst_n && (w_eff_cnt < MAX_W) && !w_stall;
  assign w_accept    = instr_req_i && instr_gnt_o;

  // Preload write port; active regardless of reset.
  always_ff @(posedge clk) begin
    if (load_we_i) begin
      r_mem[load_addr_i] <= load_wdata_i;
    end
  end

  // Shift valid/data through the pipeline; data stages only load behind a valid so the
  // output word holds its last value while rvalid is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_dat[i] <= '0;
      end
    end else begin
      r_vld[0] <= w_accept;
      if (w_accept) begin
        r_dat[0] <= w_rd;
      end
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        if (r_vld[i-1]) begin
          r_dat[i] <= r_dat[i-1];
        end
      end
    end
  end

  // Outstanding count: up on accept, down on retire, unchanged when both coincide.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      case ({w_accept, w_rvalid})
        2'b10:   r_cnt <= r_cnt + 3'd1;
        2'b01:   r_cnt <= r_cnt - 3'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign instr_rvalid_o = w_rvalid;
  assign instr_rdata_o  = r_dat[LATENCY-1];
  assign outstanding_o  = r_cnt;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench for instr_mem_responder: two instances, LATENCY=1 (u_dut1) and LATENCY=3 (u_dut3),
// both MAX_OUTSTANDING=2, sharing clock, reset and preload port. Inputs are driven at the
// falling edge and outputs sampled 1 ns later, well clear of the rising edge.
module tb_instr_mem_responder;

  logic        clk;
  logic        rst_n;
  logic        load_we;
  logic [9:0]  load_addr;
  logic [31:0] load_wdata;

  logic        req1, gnt1, rv1;
  logic [31:0] addr1, rd1;
  logic [2:0]  out1;
  logic        req3, gnt3, rv3;
  logic [31:0] addr3, rd3;
  logic [2:0]  out3;

  int total = 0;
  int bad   = 0;

  logic [31:0] words [4];

  instr_mem_responder #(.WORD_WIDTH(32), .DEPTH_LOG2(10), .LATENCY(1), .MAX_OUTSTANDING(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .instr_req_i(req1), .instr_addr_i(addr1), .instr_gnt_o(gnt1),
    .instr_rvalid_o(rv1), .instr_rdata_o(rd1),
    .load_we_i(load_we), .load_addr_i(load_addr), .load_wdata_i(load_wdata),
    .outstanding_o(out1)
  );

  instr_mem_responder #(.WORD_WIDTH(32), .DEPTH_LOG2(10), .LATENCY(3), .MAX_OUTSTANDING(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .instr_req_i(req3), .instr_addr_i(addr3), .instr_gnt_o(gnt3),
    .instr_rvalid_o(rv3), .instr_rdata_o(rd3),
    .load_we_i(load_we), .load_addr_i(load_addr), .load_wdata_i(load_wdata),
    .outstanding_o(out3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n = 1'b0;
    req1 = 1'b1; addr1 = 32'h0;
    req3 = 1'b1; addr3 = 32'h0;
    // Preload during reset: words 0..3 and word 5.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      load_we    = 1'b1;
      load_addr  = (k < 4) ? 10'(k) : 10'd5;
      load_wdata = (k < 4) ? words[k] : 32'h1111_1111;
      #1;
      total++; if (gnt1 !== 1'b0) begin bad++; $display("FAIL reset_gnt1 actual=%b required=0", gnt1); end
      total++; if (gnt3 !== 1'b0) begin bad++; $display("FAIL reset_gnt3 actual=%b required=0", gnt3); end
    end
    @(negedge clk);
    load_we = 1'b0;
    #1;
    total++; if (rv1 !== 1'b0)    begin bad++; $display("FAIL reset_rv1 actual=%b required=0", rv1); end
    total++; if (rd1 !== 32'h0)   begin bad++; $display("FAIL reset_rd1 actual=%h required=0", rd1); end
    total++; if (out1 !== 3'd0)   begin bad++; $display("FAIL reset_out1 actual=%0d required=0", out1); end
    total++; if (rv3 !== 1'b0)    begin bad++; $display("FAIL reset_rv3 actual=%b required=0", rv3); end
    total++; if (rd3 !== 32'h0)   begin bad++; $display("FAIL reset_rd3 actual=%h required=0", rd3); end
    total++; if (out3 !== 3'd0)   begin bad++; $display("FAIL reset_out3 actual=%0d required=0", out3); end
    @(negedge clk);
    rst_n = 1'b1; req1 = 1'b0; req3 = 1'b0;
  endtask

  task automatic test_stream_lat1();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      req1  = (i < 4);
      addr1 = 32'(i * 4);
      #1;
      total++; if (gnt1 !== (i < 4)) begin bad++; $display("FAIL stream_gnt c%0d actual=%b required=%b", i, gnt1, (i < 4)); end
      total++; if (rv1 !== (i >= 1 && i <= 4)) begin bad++; $display("FAIL stream_rv c%0d actual=%b required=%b", i, rv1, (i >= 1 && i <= 4)); end
      if (i >= 1 && i <= 4) begin
        total++; if (rd1 !== words[i-1]) begin bad++; $display("FAIL stream_rd c%0d actual=%h required=%h", i, rd1, words[i-1]); end
      end
      if (i == 5) begin
        total++; if (rd1 !== words[3]) begin bad++; $display("FAIL stream_hold actual=%h required=%h", rd1, words[3]); end
      end
      total++; if (out1 !== ((i >= 1 && i <= 4) ? 3'd1 : 3'd0)) begin bad++; $display("FAIL stream_out c%0d actual=%0d", i, out1); end
    end
  endtask

  task automatic test_lat3_limit();
    bit gh [16];
    int acc = 0;
    int ret = 0;
    bit exp_g, exp_rv;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      req3  = (i < 12);
      addr3 = 32'((acc % 4) * 4);
      #1;
      exp_g  = (i < 12) && ((i % 3) != 2);
      exp_rv = (i >= 3) && gh[i-3];
      total++; if (gnt3 !== exp_g) begin bad++; $display("FAIL lat3_gnt c%0d actual=%b required=%b", i, gnt3, exp_g); end
      total++; if (rv3 !== exp_rv) begin bad++; $display("FAIL lat3_rv c%0d actual=%b required=%b", i, rv3, exp_rv); end
      total++; if (out3 !== 3'(acc - ret)) begin bad++; $display("FAIL lat3_out c%0d actual=%0d required=%0d", i, out3, acc - ret); end
      if (exp_rv) begin
        total++; if (rd3 !== words[ret % 4]) begin bad++; $display("FAIL lat3_rd c%0d actual=%h required=%h", i, rd3, words[ret % 4]); end
        ret++;
      end
      gh[i] = exp_g;
      if (exp_g) acc++;
    end
  endtask

  task automatic test_decode();
    @(negedge clk); req1 = 1'b1; addr1 = 32'h0001_0000; #1;
    total++; if (gnt1 !== 1'b1) begin bad++; $display("FAIL oob_gnt actual=%b required=1", gnt1); end
    @(negedge clk); req1 = 1'b1; addr1 = 32'h0000_0006; #1;
    total++; if (rv1 !== 1'b1 || rd1 !== 32'h0000_0013) begin bad++; $display("FAIL oob_nop actual=%b/%h required=1/00000013", rv1, rd1); end
    @(negedge clk); req1 = 1'b0; #1;
    total++; if (rv1 !== 1'b1 || rd1 !== words[1]) begin bad++; $display("FAIL misaligned actual=%b/%h required=1/%h", rv1, rd1, words[1]); end
  endtask

  task automatic test_preload_collision();
    @(negedge clk);
    req1 = 1'b1; addr1 = 32'h14;
    load_we = 1'b1; load_addr = 10'd5; load_wdata = 32'hDEAD_BEEF;
    #1;
    total++; if (gnt1 !== 1'b1) begin bad++; $display("FAIL coll_gnt actual=%b required=1", gnt1); end
    @(negedge clk); load_we = 1'b0; req1 = 1'b1; addr1 = 32'h14; #1;
    total++; if (rd1 !== 32'h1111_1111) begin bad++; $display("FAIL coll_old actual=%h required=11111111", rd1); end
    @(negedge clk); req1 = 1'b0; #1;
    total++; if (rv1 !== 1'b1 || rd1 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL coll_new actual=%b/%h required=1/deadbeef", rv1, rd1); end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk); req3 = 1'b1; addr3 = 32'h0; #1;
    total++; if (gnt3 !== 1'b1) begin bad++; $display("FAIL mid_gnt0 actual=%b required=1", gnt3); end
    @(negedge clk); req3 = 1'b1; addr3 = 32'h4; #1;
    total++; if (gnt3 !== 1'b1 || out3 !== 3'd1) begin bad++; $display("FAIL mid_gnt1 actual=%b/%0d required=1/1", gnt3, out3); end
    @(negedge clk); rst_n = 1'b0; req3 = 1'b1; addr3 = 32'h8; #1;
    total++; if (gnt3 !== 1'b0) begin bad++; $display("FAIL mid_rst_gnt actual=%b required=0", gnt3); end
    @(negedge clk); rst_n = 1'b1; req3 = 1'b0; #1;
    total++; if (out3 !== 3'd0) begin bad++; $display("FAIL mid_rst_out actual=%0d required=0", out3); end
    for (int i = 0; i < 4; i++) begin
      total++; if (rv3 !== 1'b0) begin bad++; $display("FAIL mid_dropped c%0d actual=%b required=0", i, rv3); end
      @(negedge clk); #1;
    end
    req3 = 1'b1; addr3 = 32'hC; #1;
    total++; if (gnt3 !== 1'b1) begin bad++; $display("FAIL post_gnt actual=%b required=1", gnt3); end
    @(negedge clk); req3 = 1'b0; #1;
    @(negedge clk); #1;
    total++; if (rv3 !== 1'b0) begin bad++; $display("FAIL post_early actual=%b required=0", rv3); end
    @(negedge clk); #1;
    total++; if (rv3 !== 1'b1 || rd3 !== words[3]) begin bad++; $display("FAIL post_rd actual=%b/%h required=1/%h", rv3, rd3, words[3]); end
  endtask

`ifdef INSTR_MEM_GNT_STALL_EN
  task automatic test_stall();
    logic [15:0] m;
    bit prev_g, exp_g;
    int grants = 0;
    int resps  = 0;
    @(negedge clk); rst_n = 1'b0; req1 = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    m = 16'hACE1;
    prev_g = 1'b0;
    for (int i = 0; i < 66; i++) begin
      req1  = (i < 64);
      addr1 = 32'((grants % 4) * 4);
      #1;
      exp_g = (i < 64) && !m[0];
      total++; if (gnt1 !== exp_g) begin bad++; $display("FAIL stall_gnt c%0d actual=%b required=%b", i, gnt1, exp_g); end
      total++; if (rv1 !== prev_g) begin bad++; $display("FAIL stall_rv c%0d actual=%b required=%b", i, rv1, prev_g); end
      if (prev_g) begin
        total++; if (rd1 !== words[resps % 4]) begin bad++; $display("FAIL stall_rd c%0d actual=%h required=%h", i, rd1, words[resps % 4]); end
        resps++;
      end
      if (exp_g) grants++;
      prev_g = exp_g;
      m = {m[0] ^ m[2] ^ m[3] ^ m[5], m[15:1]};
      @(negedge clk);
    end
    total++; if (resps !== grants) begin bad++; $display("FAIL stall_count actual=%0d required=%0d", resps, grants); end
  endtask
`endif

  initial begin
    words[0] = 32'h0000_0093;
    words[1] = 32'h0010_0113;
    words[2] = 32'h0020_0193;
    words[3] = 32'h0030_0213;
    rst_n = 1'b0; load_we = 1'b0; load_addr = '0; load_wdata = '0;
    req1 = 1'b0; addr1 = '0; req3 = 1'b0; addr3 = '0;
    test_reset();
`ifdef INSTR_MEM_GNT_STALL_EN
    test_stall();
`else
    test_stream_lat1();
    test_lat3_limit();
    test_decode();
    test_preload_collision();
    test_reset_midflight();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
